bus_demux_buffer: RTL and testbench

- Receive end of the shared 32-bit datapath bus: the inverse of the 3-input bus mux.
- Takes one bus word plus a 2-bit destination select and steers it into one of three single-entry destination buffers.
- Each buffer drives its consumer through a valid/ack handshake and applies back-pressure to the bus source through bus_ready.
- Sits between the datapath bus and the register-file, ALU-operand and memory-data consumers.

---
 rtl/bus_demux_buffer_pkg.sv | 27 ++
 rtl/demux_slot.sv | 72 +++++++
 rtl/bus_demux_buffer.sv | 128 ++++++++++++
 tb/tb_bus_demux_buffer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_demux_buffer_pkg.sv
// ---------------------------------------------------------------------------
// bus_demux_buffer_pkg
// Shared constants and types for the receive end of the datapath bus.
//   BUS_WIDTH    : width of a bus word (32)
//   SEL_W        : width of the destination select (2)
//   NUM_SLOTS    : number of destination buffers (3)
//   SEL_DEST0..2 : select codes that steer a word into slot 0..2
//   SEL_ILLEGAL  : select code that drops the word and flags an error
//   slot_state_e : two-state occupancy of a single-entry slot
// ---------------------------------------------------------------------------
package bus_demux_buffer_pkg;

    localparam int BUS_WIDTH = 32;
    localparam int SEL_W     = 2;
    localparam int NUM_SLOTS = 3;

    localparam logic [SEL_W-1:0] SEL_DEST0   = 2'b00;
    localparam logic [SEL_W-1:0] SEL_DEST1   = 2'b01;
    localparam logic [SEL_W-1:0] SEL_DEST2   = 2'b10;
    localparam logic [SEL_W-1:0] SEL_ILLEGAL = 2'b11;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// ---------------------------------------------------------------------------
// demux_slot
// Single-entry destination buffer with a valid/ack handshake toward its
// consumer. Its ready is pass-through: a full slot can accept a new word in
// the same cycle its current word is acknowledged, so there is no bubble.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   wr_en       : load wr_data this edge (caller only asserts it when ready)
//   wr_data     : word to store
//   ack         : consumer takes the stored word (ignored while empty)
//   data        : stored word, holds its value after being consumed
//   valid       : slot holds an unconsumed word
//   slot_ready  : slot can take a word this cycle
// ---------------------------------------------------------------------------
module demux_slot
    import bus_demux_buffer_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             ack,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             slot_ready
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // A write always wins over an ack, so ack+write keeps the slot full
    // with the new word; an ack alone drains it.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (wr_en) begin
            data_d = wr_data;
        end
        case (state_q)
            SLOT_EMPTY: begin
                if (wr_en) begin
                    state_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (!wr_en && ack) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    always_comb begin
        data       = data_q;
        valid      = (state_q == SLOT_FULL);
        slot_ready = (state_q == SLOT_EMPTY) || ack;
    end

endmodule

// File: rtl/bus_demux_buffer.sv
// ---------------------------------------------------------------------------
// bus_demux_buffer
// Receive end of the shared datapath bus. A bus word is steered by sel into
// one of three single-entry buffers (register file, ALU operand, memory
// data). Each buffer hands its word to its consumer with valid/ack and
// back-pressures the bus through bus_ready. Illegal selects are always
// accepted and dropped, producing a one-cycle sel_err pulse.
// Ports:
//   clk, rst                 : clock and synchronous active-high reset
//   bus_in, sel, bus_valid   : bus word, destination select, word valid
//   bus_ready                : combinational; word accepted on valid&&ready
//   dout_n, dout_valid_n     : slot n word and its valid flag (n = 0..2)
//   dout_ack_n               : consumer n takes its word
//   sel_err                  : pulse after an accepted illegal-select word
//   err_count                : saturating count of dropped words, present
//                              only when BUS_DEMUX_ERR_COUNT_EN is defined
// ---------------------------------------------------------------------------
module bus_demux_buffer
    import bus_demux_buffer_pkg::*;
#(
    parameter int WIDTH     = BUS_WIDTH,
    parameter int ERR_CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [SEL_W-1:0] sel,
    input  logic             bus_valid,
    output logic             bus_ready,
    output logic [WIDTH-1:0] dout_0,
    output logic [WIDTH-1:0] dout_1,
    output logic [WIDTH-1:0] dout_2,
    output logic             dout_valid_0,
    output logic             dout_valid_1,
    output logic             dout_valid_2,
    input  logic             dout_ack_0,
    input  logic             dout_ack_1,
    input  logic             dout_ack_2,
    output logic             sel_err
`ifdef BUS_DEMUX_ERR_COUNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    logic [NUM_SLOTS-1:0] slot_ready;
    logic [NUM_SLOTS-1:0] slot_wr;
    logic [NUM_SLOTS-1:0] slot_valid;
    logic [NUM_SLOTS-1:0] slot_ack;
    logic [WIDTH-1:0]     slot_data [NUM_SLOTS];
    logic                 accept;
    logic                 sel_err_q, sel_err_d;

    assign slot_ack = {dout_ack_2, dout_ack_1, dout_ack_0};

    // Ready follows the addressed slot; an illegal select never stalls.
    always_comb begin
        bus_ready = 1'b1;
        case (sel)
            SEL_DEST0: bus_ready = slot_ready[0];
            SEL_DEST1: bus_ready = slot_ready[1];
            SEL_DEST2: bus_ready = slot_ready[2];
            default:   bus_ready = 1'b1;
        endcase
    end

    always_comb begin
        accept    = bus_valid && bus_ready;
        sel_err_d = accept && (sel == SEL_ILLEGAL);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_wr[i] = accept && (sel == SEL_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .wr_en      (slot_wr[g]),
            .wr_data    (bus_in),
            .ack        (slot_ack[g]),
            .data       (slot_data[g]),
            .valid      (slot_valid[g]),
            .slot_ready (slot_ready[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err      = sel_err_q;
    assign dout_0       = slot_data[0];
    assign dout_1       = slot_data[1];
    assign dout_2       = slot_data[2];
    assign dout_valid_0 = slot_valid[0];
    assign dout_valid_1 = slot_valid[1];
    assign dout_valid_2 = slot_valid[2];

`ifdef BUS_DEMUX_ERR_COUNT_EN
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    // Counts on the same edge that raises sel_err and sticks at all-ones.
    always_comb begin
        err_count_d = err_count_q;
        if (sel_err_d && (err_count_q != {ERR_CNT_W{1'b1}})) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_bus_demux_buffer.sv
// ---------------------------------------------------------------------------
// tb_bus_demux_buffer
// Self-checking bench for bus_demux_buffer: a vector table of per-cycle
// inputs with expected ready/valid/sel_err, a scoreboard of written words
// feeding a small dout model, and a hand-written illegal-select burst that
// also exercises the saturating counter when BUS_DEMUX_ERR_COUNT_EN is set.
// ---------------------------------------------------------------------------
module tb_bus_demux_buffer;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [1:0]  sel;
        logic [31:0] data;
        logic [2:0]  ack;
        logic        chk_ready;
        logic        exp_ready;
        logic [2:0]  exp_valid;
        logic        exp_err;
        string       name;
    } vec_t;

    typedef struct packed {
        logic [1:0]  slot;
        logic [31:0] data;
    } sb_t;

    logic        clk;
    logic        rst;
    logic [31:0] bus_in;
    logic [1:0]  sel;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] dout_0, dout_1, dout_2;
    logic        dout_valid_0, dout_valid_1, dout_valid_2;
    logic        dout_ack_0, dout_ack_1, dout_ack_2;
    logic        sel_err;
`ifdef BUS_DEMUX_ERR_COUNT_EN
    logic [1:0]  err_count;
`endif

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    sb_t  sbq[$];
    logic [31:0] exp_dout [3];

    bus_demux_buffer #(
        .WIDTH     (32),
        .ERR_CNT_W (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus_in       (bus_in),
        .sel          (sel),
        .bus_valid    (bus_valid),
        .bus_ready    (bus_ready),
        .dout_0       (dout_0),
        .dout_1       (dout_1),
        .dout_2       (dout_2),
        .dout_valid_0 (dout_valid_0),
        .dout_valid_1 (dout_valid_1),
        .dout_valid_2 (dout_valid_2),
        .dout_ack_0   (dout_ack_0),
        .dout_ack_1   (dout_ack_1),
        .dout_ack_2   (dout_ack_2),
        .sel_err      (sel_err)
`ifdef BUS_DEMUX_ERR_COUNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic r, input logic v, input logic [1:0] s,
                          input logic [31:0] d, input logic [2:0] a,
                          input logic cr, input logic er,
                          input logic [2:0] ev, input logic ee,
                          input string n);
        vec_t t;
        t.rst = r; t.valid = v; t.sel = s; t.data = d; t.ack = a;
        t.chk_ready = cr; t.exp_ready = er; t.exp_valid = ev;
        t.exp_err = ee; t.name = n;
        vecs.push_back(t);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs and records any word the model says is accepted.
    task automatic applyStimulus(input vec_t t);
        sb_t e;
        rst        = t.rst;
        bus_valid  = t.valid;
        sel        = t.sel;
        bus_in     = t.data;
        dout_ack_0 = t.ack[0];
        dout_ack_1 = t.ack[1];
        dout_ack_2 = t.ack[2];
        if (!t.rst && t.valid && t.exp_ready && t.sel != 2'b11) begin
            e.slot = t.sel;
            e.data = t.data;
            sbq.push_back(e);
        end
    endtask

    // Applies scoreboard entries for the edge just taken, then compares douts.
    task automatic updateAndCheckDout(input logic was_rst, input string name);
        sb_t e;
        if (was_rst) begin
            sbq.delete();
            for (int i = 0; i < 3; i++) exp_dout[i] = 32'h0;
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            exp_dout[e.slot] = e.data;
        end
        checkOutput({name, " dout_0"}, dout_0, exp_dout[0]);
        checkOutput({name, " dout_1"}, dout_1, exp_dout[1]);
        checkOutput({name, " dout_2"}, dout_2, exp_dout[2]);
    endtask

    initial begin
        int cnt_model;
        rst = 1'b1; bus_valid = 1'b0; sel = 2'b00; bus_in = '0;
        dout_ack_0 = 1'b0; dout_ack_1 = 1'b0; dout_ack_2 = 1'b0;
        for (int i = 0; i < 3; i++) exp_dout[i] = 32'h0;

        //      rst  vld  sel    data           ack     chkR er  exp_valid err name
        addVec(1'b1,1'b0,2'b00,32'h0,          3'b000, 1'b0,1'b0,3'b000,1'b0,"reset1");
        addVec(1'b1,1'b0,2'b00,32'h0,          3'b000, 1'b1,1'b1,3'b000,1'b0,"reset2");
        addVec(1'b0,1'b0,2'b00,32'h0,          3'b000, 1'b1,1'b1,3'b000,1'b0,"idle_sel0");
        addVec(1'b0,1'b0,2'b01,32'h0,          3'b000, 1'b1,1'b1,3'b000,1'b0,"idle_sel1");
        addVec(1'b0,1'b0,2'b10,32'h0,          3'b000, 1'b1,1'b1,3'b000,1'b0,"idle_sel2");
        addVec(1'b0,1'b0,2'b11,32'h0,          3'b000, 1'b1,1'b1,3'b000,1'b0,"idle_sel3");
        addVec(1'b0,1'b1,2'b10,32'h0000_0155,  3'b000, 1'b1,1'b1,3'b100,1'b0,"steer_slot2");
        addVec(1'b0,1'b0,2'b00,32'h0,          3'b000, 1'b1,1'b1,3'b100,1'b0,"idle_after_steer");
        addVec(1'b0,1'b1,2'b00,32'h1,          3'b000, 1'b1,1'b1,3'b101,1'b0,"fill_slot0");
        addVec(1'b0,1'b1,2'b00,32'h2,          3'b000, 1'b1,1'b0,3'b101,1'b0,"bp_stall_a");
        addVec(1'b0,1'b1,2'b00,32'h2,          3'b000, 1'b1,1'b0,3'b101,1'b0,"bp_stall_b");
        addVec(1'b0,1'b1,2'b00,32'h2,          3'b001, 1'b1,1'b1,3'b101,1'b0,"bp_ack_write");
        addVec(1'b0,1'b1,2'b01,32'hABCD_0001,  3'b000, 1'b1,1'b1,3'b111,1'b0,"fill_slot1");
        addVec(1'b0,1'b0,2'b01,32'h0,          3'b010, 1'b1,1'b1,3'b101,1'b0,"drain_slot1");
        addVec(1'b0,1'b0,2'b01,32'h0,          3'b010, 1'b1,1'b1,3'b101,1'b0,"ack_while_empty");
        addVec(1'b0,1'b1,2'b11,32'hFFFF_FFFF,  3'b000, 1'b1,1'b1,3'b101,1'b1,"illegal_1");
        addVec(1'b0,1'b1,2'b11,32'hFFFF_FFFF,  3'b000, 1'b1,1'b1,3'b101,1'b1,"illegal_2");
        addVec(1'b0,1'b1,2'b11,32'hFFFF_FFFF,  3'b000, 1'b1,1'b1,3'b101,1'b1,"illegal_3");
        addVec(1'b0,1'b0,2'b00,32'hDEAD_BEEF,  3'b000, 1'b1,1'b0,3'b101,1'b0,"invalid_ignored");
        addVec(1'b0,1'b1,2'b01,32'h5,          3'b001, 1'b1,1'b1,3'b110,1'b0,"ack0_write1");
        addVec(1'b0,1'b1,2'b00,32'h7,          3'b000, 1'b1,1'b1,3'b111,1'b0,"refill_slot0");
        addVec(1'b1,1'b1,2'b01,32'h9,          3'b010, 1'b1,1'b1,3'b000,1'b0,"reset_midop");
        addVec(1'b0,1'b0,2'b00,32'h0,          3'b000, 1'b1,1'b1,3'b000,1'b0,"idle_after_rst");

        foreach (vecs[k]) begin
            @(negedge clk);
            applyStimulus(vecs[k]);
            #1;
            if (vecs[k].chk_ready)
                checkOutput({vecs[k].name, " bus_ready"}, 32'(bus_ready), 32'(vecs[k].exp_ready));
            @(posedge clk);
            #1;
            checkOutput({vecs[k].name, " dout_valid"},
                        32'({dout_valid_2, dout_valid_1, dout_valid_0}), 32'(vecs[k].exp_valid));
            checkOutput({vecs[k].name, " sel_err"}, 32'(sel_err), 32'(vecs[k].exp_err));
            updateAndCheckDout(vecs[k].rst, vecs[k].name);
        end

`ifdef BUS_DEMUX_ERR_COUNT_EN
        checkOutput("cnt_after_reset err_count", 32'(err_count), 32'd0);
`endif

        // Five back-to-back illegal words: continuous sel_err, counter sticks at 3.
        cnt_model = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rst = 1'b0; bus_valid = 1'b1; sel = 2'b11; bus_in = 32'hFFFF_FFFF;
            dout_ack_0 = 1'b0; dout_ack_1 = 1'b0; dout_ack_2 = 1'b0;
            #1;
            checkOutput($sformatf("burst%0d bus_ready", k), 32'(bus_ready), 32'd1);
            @(posedge clk);
            #1;
            cnt_model = (cnt_model == 3) ? 3 : cnt_model + 1;
            checkOutput($sformatf("burst%0d sel_err", k), 32'(sel_err), 32'd1);
            checkOutput($sformatf("burst%0d dout_valid", k),
                        32'({dout_valid_2, dout_valid_1, dout_valid_0}), 32'd0);
`ifdef BUS_DEMUX_ERR_COUNT_EN
            checkOutput($sformatf("burst%0d err_count", k), 32'(err_count), 32'(cnt_model));
`endif
        end

        @(negedge clk);
        bus_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("burst_end sel_err", 32'(sel_err), 32'd0);
        updateAndCheckDout(1'b0, "burst_end");
`ifdef BUS_DEMUX_ERR_COUNT_EN
        checkOutput("burst_end err_count", 32'(err_count), 32'(cnt_model));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("cnt_cleared err_count", 32'(err_count), 32'd0);
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
